multicycle_core: RTL and testbench
==================================

MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter WORDSIZE, default 64, SHALL set datapath, register and PC width.
REQ-002 Parameter NREGS, default 32, SHALL set register count; register index width is clog2(NREGS).
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC value loaded at reset.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 instr_valid  input  1  instruction word offered.
REQ-007 instr  input  32  RV64I-encoded instruction.
REQ-008 instr_ready  output  1  core accepts an instruction this cycle.
REQ-009 pc  output  WORDSIZE  address of the instruction being requested or executed.
REQ-010 mem_req, mem_we  output  1 each  data-memory request and write strobe.
REQ-011 mem_addr, mem_wdata  output  WORDSIZE each  byte address and store data.
REQ-012 mem_ack  input  1  memory completed request; mem_rdata  input  WORDSIZE  load data, valid with mem_ack.
REQ-013 halted  output  1  core stopped on an illegal or misaligned instruction.

Function
REQ-014 The FSM SHALL have the states FETCH, DECODE, EXECUTE, MEM, WB and HALT.
REQ-015 instr_ready SHALL be 1 only in FETCH; on instr_valid&&instr_ready the instruction SHALL be latched into IR and the state SHALL move to DECODE; without instr_valid the FSM SHALL stay in FETCH.
REQ-016 Supported operations SHALL be ADD, SUB, AND, OR, XOR, SLT, ADDI, LD, SD and BEQ; any other opcode/funct SHALL go DECODE->HALT.
REQ-017 DECODE SHALL read rs1/rs2 and sign-extend the I/S/B immediate to WORDSIZE.
REQ-018 EXECUTE SHALL compute the ALU result (the effective address for LD/SD); the next state SHALL be MEM for LD/SD, FETCH for BEQ, and WB otherwise.
REQ-019 BEQ SHALL set pc to pc+imm when rs1==rs2 and to pc+4 otherwise, at the EXECUTE->FETCH edge.
REQ-020 All other instructions SHALL advance pc by 4 on entry to FETCH; PC arithmetic SHALL wrap modulo 2^WORDSIZE.
REQ-021 In MEM, mem_req SHALL be held at 1 with mem_addr, mem_we and mem_wdata stable until mem_ack; the request SHALL be dropped in the cycle after mem_ack.
REQ-022 A store SHALL go MEM->FETCH on mem_ack; a load SHALL capture mem_rdata on mem_ack and go to WB.
REQ-023 An LD/SD address with a nonzero value in bits [2:0] SHALL go to HALT without asserting mem_req.
REQ-024 mem_ack outside MEM SHALL be ignored.
REQ-025 WB SHALL write rd, then go to FETCH; writes to x0 SHALL be discarded, and reads of x0 SHALL return 0.
REQ-026 Latency, handshake to next instr_ready: ALU ops and ADDI take 4 cycles, BEQ takes 3, and LD/SD take 4 or 5 plus the mem_ack wait.
REQ-027 HALT SHALL be absorbing: halted=1, instr_ready=0, mem_req=0, and pc frozen until reset.
REQ-028 SLT SHALL be signed; ALU overflow SHALL be ignored.

Reset
REQ-029 On rst_n=0 the state SHALL become FETCH, pc SHALL become RESET_PC, and IR, mem_req, mem_we and halted SHALL become 0, asynchronously and without waiting for clk.
REQ-030 Reset during MEM SHALL drop mem_req immediately; a later mem_ack SHALL be ignored.
REQ-031 Register-file contents SHALL be reset to 0.

Structure
REQ-032 A package core_pkg SHALL hold the state enum, the opcode/funct constants and the ALU operation encoding.
REQ-033 Combinational arithmetic SHALL be placed in one sub-module, alu (3-bit operation, result, overflow); the register file and FSM SHALL stay inline.

Verification
REQ-034 Reset, then ADDI x1,x0,5 then ADDI x2,x0,7 then ADD x3,x1,x2 -> x3=12, pc=RESET_PC+12, 4 cycles per instruction.
REQ-035 SD x3,8(x0) with mem_ack delayed 3 cycles -> mem_req high for 4 cycles, mem_addr=8, mem_wdata=12 stable throughout; then LD x4,8(x0) with mem_rdata=12 -> x4=12.
REQ-036 BEQ x1,x1,-8 at pc=0x20 -> next pc=0x18; BEQ x1,x2,-8 -> pc=0x24.
REQ-037 ADDI x0,x0,9, then ADD x5,x0,x0 -> x5=0; the x0 write is discarded.
REQ-038 LD with address 0x0C -> halted=1, mem_req never asserted, instr_ready=0 for 10 cycles; an undefined opcode 0x7F also -> halted.
REQ-039 rst_n low while in MEM waiting on ack -> mem_req=0 in the same cycle, pc=RESET_PC; mem_ack pulsed afterwards -> no register change.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for multicycle_core.
//   state_t  - control FSM states
//   alu_op_t - 3-bit ALU operation encoding consumed by alu
//   kind_t   - instruction class captured at decode
//   OP_*/F3_*/F7_* - RV64I opcode and funct fields of the supported subset
package core_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_t;

  typedef enum logic [1:0] {
    K_ALU = 2'd0,
    K_LD  = 2'd1,
    K_SD  = 2'd2,
    K_BEQ = 2'd3
  } kind_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_DWORD   = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/multicycle_core_alu.sv
// alu: combinational datapath arithmetic for multicycle_core.
//   i_a, i_b   - operands (WORDSIZE)
//   i_op       - 3-bit operation (alu_op_t)
//   o_result   - result (WORDSIZE); SLT yields 0 or 1, signed compare
//   o_overflow - signed overflow flag for ADD/SUB, 0 otherwise
module alu
  import core_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic [WORDSIZE-1:0] i_a,
  input  logic [WORDSIZE-1:0] i_b,
  input  alu_op_t             i_op,
  output logic [WORDSIZE-1:0] o_result,
  output logic                o_overflow
);

  logic [WORDSIZE-1:0] w_sum;
  logic [WORDSIZE-1:0] w_diff;
  logic                w_lt;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_lt   = $signed(i_a) < $signed(i_b);

  // Operation select and overflow detection
  always_comb begin
    o_result   = {WORDSIZE{1'b0}};
    o_overflow = 1'b0;
    case (i_op)
      ALU_ADD: begin
        o_result   = w_sum;
        o_overflow = (i_a[WORDSIZE-1] == i_b[WORDSIZE-1]) &&
                     (w_sum[WORDSIZE-1] != i_a[WORDSIZE-1]);
      end
      ALU_SUB: begin
        o_result   = w_diff;
        o_overflow = (i_a[WORDSIZE-1] != i_b[WORDSIZE-1]) &&
                     (w_diff[WORDSIZE-1] != i_a[WORDSIZE-1]);
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_SLT: o_result = {{(WORDSIZE-1){1'b0}}, w_lt};
      default: o_result = {WORDSIZE{1'b0}};
    endcase
  end

endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: RV64I-subset multicycle core
// (ADD SUB AND OR XOR SLT ADDI LD SD BEQ).
// FSM FETCH -> DECODE -> EXECUTE -> {MEM, WB, FETCH}; HALT is absorbing.
//   clk, rst_n               - clock, async active-low reset
//   instr_valid/instr        - offered instruction; instr_ready only in FETCH
//   pc                       - address of the current instruction
//   mem_req/mem_we           - data request and write strobe, held until mem_ack
//   mem_addr/mem_wdata       - byte address and store data
//   mem_ack/mem_rdata        - completion and load data
//   halted                   - stopped on illegal or misaligned instruction
module multicycle_core
  import core_pkg::*;
#(
  parameter int                  WORDSIZE = 64,
  parameter int                  NREGS    = 32,
  parameter logic [WORDSIZE-1:0] RESET_PC = {WORDSIZE{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [31:0]         instr,
  output logic                instr_ready,
  output logic [WORDSIZE-1:0] pc,
  output logic                mem_req,
  output logic                mem_we,
  output logic [WORDSIZE-1:0] mem_addr,
  output logic [WORDSIZE-1:0] mem_wdata,
  input  logic                mem_ack,
  input  logic [WORDSIZE-1:0] mem_rdata,
  output logic                halted
);

  localparam int RIDX = $clog2(NREGS);

  state_t              r_state;
  logic [31:0]         r_ir;
  logic [WORDSIZE-1:0] r_pc;
  logic [WORDSIZE-1:0] r_a;
  logic [WORDSIZE-1:0] r_b;
  logic [WORDSIZE-1:0] r_imm;
  logic [WORDSIZE-1:0] r_result;
  kind_t               r_kind;
  alu_op_t             r_alu_op;
  logic                r_use_imm;
  logic [RIDX-1:0]     r_rd;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [WORDSIZE-1:0] r_mem_addr;
  logic [WORDSIZE-1:0] r_mem_wdata;
  logic                r_halted;
  logic [WORDSIZE-1:0] r_regs [NREGS];

  logic [6:0]          w_opcode;
  logic [2:0]          w_f3;
  logic [6:0]          w_f7;
  logic [RIDX-1:0]     w_rs1_idx;
  logic [RIDX-1:0]     w_rs2_idx;
  logic [RIDX-1:0]     w_rd_idx;
  logic [WORDSIZE-1:0] w_rs1_val;
  logic [WORDSIZE-1:0] w_rs2_val;
  logic [WORDSIZE-1:0] w_imm_i;
  logic [WORDSIZE-1:0] w_imm_s;
  logic [WORDSIZE-1:0] w_imm_b;
  logic                w_legal;
  kind_t               w_kind;
  alu_op_t             w_op;
  logic                w_use_imm;
  logic [WORDSIZE-1:0] w_imm;
  logic [WORDSIZE-1:0] w_alu_b;
  logic [WORDSIZE-1:0] w_alu_result;
  logic                w_unused_ovf;
  logic [WORDSIZE-1:0] w_pc_plus4;
  logic [WORDSIZE-1:0] w_pc_branch;
  logic                w_eq;

  assign w_opcode  = r_ir[6:0];
  assign w_f3      = r_ir[14:12];
  assign w_f7      = r_ir[31:25];
  assign w_rs1_idx = r_ir[15 +: RIDX];
  assign w_rs2_idx = r_ir[20 +: RIDX];
  assign w_rd_idx  = r_ir[7 +: RIDX];

  // x0 is hardwired to zero on read
  assign w_rs1_val = (w_rs1_idx == {RIDX{1'b0}}) ? {WORDSIZE{1'b0}} : r_regs[w_rs1_idx];
  assign w_rs2_val = (w_rs2_idx == {RIDX{1'b0}}) ? {WORDSIZE{1'b0}} : r_regs[w_rs2_idx];

  assign w_imm_i = {{(WORDSIZE-12){r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{(WORDSIZE-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{(WORDSIZE-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

  // Instruction decode of IR: legality, class, ALU op and immediate
  always_comb begin
    w_legal   = 1'b0;
    w_kind    = K_ALU;
    w_op      = ALU_ADD;
    w_use_imm = 1'b0;
    w_imm     = w_imm_i;
    case (w_opcode)
      OP_REG: begin
        if (w_f7 == F7_BASE) begin
          w_legal = 1'b1;
          case (w_f3)
            F3_ADD_SUB: w_op = ALU_ADD;
            F3_SLT:     w_op = ALU_SLT;
            F3_XOR:     w_op = ALU_XOR;
            F3_OR:      w_op = ALU_OR;
            F3_AND:     w_op = ALU_AND;
            default:    w_legal = 1'b0;
          endcase
        end else if ((w_f7 == F7_SUB) && (w_f3 == F3_ADD_SUB)) begin
          w_legal = 1'b1;
          w_op    = ALU_SUB;
        end else begin
          w_legal = 1'b0;
        end
      end
      OP_IMM: begin
        w_legal   = (w_f3 == F3_ADD_SUB);
        w_use_imm = 1'b1;
      end
      OP_LOAD: begin
        w_legal   = (w_f3 == F3_DWORD);
        w_kind    = K_LD;
        w_use_imm = 1'b1;
      end
      OP_STORE: begin
        w_legal   = (w_f3 == F3_DWORD);
        w_kind    = K_SD;
        w_use_imm = 1'b1;
        w_imm     = w_imm_s;
      end
      OP_BRANCH: begin
        // Equality is tested as a zero ALU difference
        w_legal = (w_f3 == F3_BEQ);
        w_kind  = K_BEQ;
        w_op    = ALU_SUB;
        w_imm   = w_imm_b;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_alu_b     = r_use_imm ? r_imm : r_b;
  assign w_pc_plus4  = r_pc + {{(WORDSIZE-3){1'b0}}, 3'd4};
  assign w_pc_branch = r_pc + r_imm;
  assign w_eq        = (w_alu_result == {WORDSIZE{1'b0}});

  alu #(.WORDSIZE(WORDSIZE)) u_alu (
    .i_a        (r_a),
    .i_b        (w_alu_b),
    .i_op       (r_alu_op),
    .o_result   (w_alu_result),
    .o_overflow (w_unused_ovf)
  );

  // Control FSM, PC, register file and memory interface registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_ir        <= 32'd0;
      r_pc        <= RESET_PC;
      r_a         <= {WORDSIZE{1'b0}};
      r_b         <= {WORDSIZE{1'b0}};
      r_imm       <= {WORDSIZE{1'b0}};
      r_result    <= {WORDSIZE{1'b0}};
      r_kind      <= K_ALU;
      r_alu_op    <= ALU_ADD;
      r_use_imm   <= 1'b0;
      r_rd        <= {RIDX{1'b0}};
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {WORDSIZE{1'b0}};
      r_mem_wdata <= {WORDSIZE{1'b0}};
      r_halted    <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {WORDSIZE{1'b0}};
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_state <= S_DECODE;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_a       <= w_rs1_val;
            r_b       <= w_rs2_val;
            r_imm     <= w_imm;
            r_kind    <= w_kind;
            r_alu_op  <= w_op;
            r_use_imm <= w_use_imm;
            r_rd      <= w_rd_idx;
            r_state   <= S_EXECUTE;
          end else begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end
        end
        S_EXECUTE: begin
          case (r_kind)
            K_BEQ: begin
              r_pc    <= w_eq ? w_pc_branch : w_pc_plus4;
              r_state <= S_FETCH;
            end
            K_LD, K_SD: begin
              // Misaligned doubleword access halts before any request goes out
              if (w_alu_result[2:0] != 3'b000) begin
                r_halted <= 1'b1;
                r_state  <= S_HALT;
              end else begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= (r_kind == K_SD);
                r_mem_addr  <= w_alu_result;
                r_mem_wdata <= r_b;
                r_state     <= S_MEM;
              end
            end
            default: begin
              r_result <= w_alu_result;
              r_state  <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_kind == K_SD) begin
              r_pc    <= w_pc_plus4;
              r_state <= S_FETCH;
            end else begin
              r_result <= mem_rdata;
              r_state  <= S_WB;
            end
          end else begin
            r_state <= S_MEM;
          end
        end
        S_WB: begin
          if (r_rd != {RIDX{1'b0}}) begin
            r_regs[r_rd] <= r_result;
          end
          r_pc    <= w_pc_plus4;
          r_state <= S_FETCH;
        end
        S_HALT: begin
          r_halted <= 1'b1;
          r_state  <= S_HALT;
        end
        default: begin
          r_halted <= 1'b1;
          r_state  <= S_HALT;
        end
      endcase
    end
  end

  assign instr_ready = (r_state == S_FETCH);
  assign pc          = r_pc;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign halted      = r_halted;

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed and randomized checks of multicycle_core
// against an instruction-level reference model (register array, PC and
// an associative data memory). Register contents are observed through
// the store data of SD instructions.
module tb_multicycle_core;

  typedef enum {I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLT, I_ADDI, I_LD, I_SD, I_BEQ, I_BAD} iop_e;
  typedef struct {
    iop_e   op;
    int     rd;
    int     rs1;
    int     rs2;
    longint imm;
  } ins_t;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [63:0] pc;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] m_regs [32];
  logic [63:0] m_pc;
  logic [63:0] env_mem [logic [63:0]];

  multicycle_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .pc          (pc),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return a ^ 64'h5A5A_0000_F0F0_1234;
  endfunction

  function automatic logic [63:0] rv(input int r);
    return (r == 0) ? 64'd0 : m_regs[r];
  endfunction

  function automatic ins_t mk(input iop_e op, input int rd, input int rs1, input int rs2, input longint imm);
    ins_t t;
    t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
    return t;
  endfunction

  // RV64I encodings of the supported subset
  function automatic logic [31:0] encode(input ins_t t);
    logic [63:0] iv;
    logic [4:0]  d, s1, s2;
    iv = t.imm; d = 5'(t.rd); s1 = 5'(t.rs1); s2 = 5'(t.rs2);
    case (t.op)
      I_ADD:  return {7'b0000000, s2, s1, 3'b000, d, 7'b0110011};
      I_SUB:  return {7'b0100000, s2, s1, 3'b000, d, 7'b0110011};
      I_AND:  return {7'b0000000, s2, s1, 3'b111, d, 7'b0110011};
      I_OR:   return {7'b0000000, s2, s1, 3'b110, d, 7'b0110011};
      I_XOR:  return {7'b0000000, s2, s1, 3'b100, d, 7'b0110011};
      I_SLT:  return {7'b0000000, s2, s1, 3'b010, d, 7'b0110011};
      I_ADDI: return {iv[11:0], s1, 3'b000, d, 7'b0010011};
      I_LD:   return {iv[11:0], s1, 3'b011, d, 7'b0000011};
      I_SD:   return {iv[11:5], s2, s1, 3'b011, iv[4:0], 7'b0100011};
      I_BEQ:  return {iv[12], iv[10:5], s2, s1, 3'b000, iv[4:1], iv[11], 7'b1100011};
      default: return 32'h0000_007F;
    endcase
  endfunction

  function automatic ins_t rand_ins();
    ins_t t;
    int   k;
    k = $urandom_range(0, 9);
    t = mk(I_ADD, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0);
    case (k)
      0: t.op = I_ADD;
      1: t.op = I_SUB;
      2: t.op = I_AND;
      3: t.op = I_OR;
      4: t.op = I_XOR;
      5: t.op = I_SLT;
      6: begin t.op = I_ADDI; t.imm = longint'($urandom_range(0, 4095)) - 2048; end
      7: begin t.op = I_LD; t.rs1 = 0; t.imm = 8 * longint'($urandom_range(0, 255)); end
      8: begin t.op = I_SD; t.rs1 = 0; t.imm = 8 * longint'($urandom_range(0, 255)); end
      default: begin t.op = I_BEQ; t.imm = 4 * longint'($urandom_range(0, 32)) - 64; end
    endcase
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_pc = 64'd0;
  endtask

  // Assert reset mid-cycle and check its effect before the next clock edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0;
    #1;
    check_eq("rst_pc", pc, 64'd0);
    check_eq("rst_ready", instr_ready, 1'b1);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_halted", halted, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input ins_t t, input int dly);
    logic [63:0] a, b, ea, res;
    bit          misal, halt_exp, done;
    int          lat_exp, cyc, reqcnt, waitc;
    a = rv(t.rs1); b = rv(t.rs2);
    ea = a + t.imm;
    misal = ((t.op == I_LD) || (t.op == I_SD)) && (ea[2:0] != 3'b000);
    halt_exp = (t.op == I_BAD) || misal;
    case (t.op)
      I_ADD:  res = a + b;
      I_SUB:  res = a - b;
      I_AND:  res = a & b;
      I_OR:   res = a | b;
      I_XOR:  res = a ^ b;
      I_SLT:  res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      I_ADDI: res = a + t.imm;
      I_LD:   res = mem_rd(ea);
      default: res = 64'd0;
    endcase
    case (t.op)
      I_BEQ:   lat_exp = 3;
      I_SD:    lat_exp = 4 + dly;
      I_LD:    lat_exp = 5 + dly;
      default: lat_exp = 4;
    endcase
    waitc = 0;
    while (!instr_ready && waitc < 64) begin
      @(negedge clk);
      waitc++;
    end
    check_eq("ready_wait", instr_ready, 1'b1);
    check_eq("pc_issue", pc, m_pc);
    instr = encode(t);
    instr_valid = 1'b1;
    @(posedge clk);
    cyc = 0; reqcnt = 0; done = 0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      instr_valid = 1'b0;
      cyc++;
      if (mem_req) begin
        reqcnt++;
        check_eq("mem_addr", mem_addr, ea);
        check_eq("mem_we", mem_we, (t.op == I_SD));
        if (t.op == I_SD) check_eq("mem_wdata", mem_wdata, b);
        if (reqcnt == dly + 1) begin
          mem_ack = 1'b1;
          if (mem_we) env_mem[mem_addr] = mem_wdata;
          mem_rdata = mem_rd(mem_addr);
        end else begin
          mem_ack = 1'b0;
          mem_rdata = {$urandom, $urandom};
        end
      end else begin
        // Stray acknowledges outside a request must have no effect
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = {$urandom, $urandom};
      end
      if (instr_ready || halted) done = 1;
    end
    mem_ack = 1'b0;
    check_eq("completes", done, 1'b1);
    if (halt_exp) begin
      check_eq("halted", halted, 1'b1);
      check_eq("halt_no_req", reqcnt, 0);
      check_eq("halt_pc", pc, m_pc);
      for (int i = 0; i < 10; i++) begin
        instr_valid = 1'b1;
        instr = $urandom;
        mem_ack = $urandom_range(0, 1);
        @(negedge clk);
        check_eq("halt_ready", instr_ready, 1'b0);
        check_eq("halt_mem_req", mem_req, 1'b0);
        check_eq("halt_stuck", halted, 1'b1);
        check_eq("halt_pc_frozen", pc, m_pc);
      end
      instr_valid = 1'b0;
      mem_ack = 1'b0;
    end else begin
      check_eq("not_halted", halted, 1'b0);
      check_eq("latency", cyc, lat_exp);
      if ((t.op == I_LD) || (t.op == I_SD)) check_eq("req_cycles", reqcnt, dly + 1);
      case (t.op)
        I_SD:  m_pc = m_pc + 64'd4;
        I_BEQ: m_pc = (a == b) ? m_pc + t.imm : m_pc + 64'd4;
        default: begin
          if (t.rd != 0) m_regs[t.rd] = res;
          m_pc = m_pc + 64'd4;
        end
      endcase
    end
  endtask

  initial begin
    int wc;
    rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0; mem_ack = 1'b0; mem_rdata = 64'd0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Basic ALU chain, store with delayed ack, load back
    run_instr(mk(I_ADDI, 1, 0, 0, 5), 0);
    run_instr(mk(I_ADDI, 2, 0, 0, 7), 0);
    run_instr(mk(I_ADD, 3, 1, 2, 0), 0);
    check_eq("pc_after_3", pc, 64'd12);
    run_instr(mk(I_SD, 0, 0, 3, 8), 3);
    check_eq("stored_12", env_mem[64'd8], 64'd12);
    run_instr(mk(I_LD, 4, 0, 0, 8), 1);
    run_instr(mk(I_SD, 0, 0, 4, 16), 0);
    check_eq("x4_is_12", env_mem[64'd16], 64'd12);
    // x0 writes discarded
    run_instr(mk(I_ADDI, 0, 0, 0, 9), 0);
    run_instr(mk(I_ADD, 5, 0, 0, 0), 0);
    // Branches: at 0x20 taken -8 -> 0x18; at 0x18 taken +8 -> 0x20; not taken -> 0x24
    run_instr(mk(I_BEQ, 0, 1, 1, -8), 0);
    check_eq("beq_taken", pc, 64'h18);
    run_instr(mk(I_BEQ, 0, 1, 1, 8), 0);
    run_instr(mk(I_BEQ, 0, 1, 2, -8), 0);
    check_eq("beq_not_taken", pc, 64'h24);
    run_instr(mk(I_SD, 0, 0, 5, 24), 2);
    check_eq("x5_is_0", env_mem[64'd24], 64'd0);
    // Signed compare
    run_instr(mk(I_ADDI, 6, 0, 0, -1), 0);
    run_instr(mk(I_SLT, 7, 6, 1, 0), 0);
    run_instr(mk(I_SD, 0, 0, 7, 32), 0);
    check_eq("slt_signed", env_mem[64'd32], 64'd1);

    // Randomized program, then dump registers through stores
    for (int n = 0; n < 200; n++) begin
      run_instr(rand_ins(), $urandom_range(0, 3));
    end
    for (int r = 1; r < 8; r++) begin
      run_instr(mk(I_SD, 0, 0, r, 1024 + 8 * r), $urandom_range(0, 2));
    end

    // Misaligned load halts without a request
    do_reset();
    run_instr(mk(I_ADDI, 1, 0, 0, 4), 0);
    run_instr(mk(I_LD, 4, 1, 0, 8), 0);
    // Undefined opcode halts
    do_reset();
    run_instr(mk(I_BAD, 0, 0, 0, 0), 0);

    // Reset while waiting for a store acknowledge
    do_reset();
    run_instr(mk(I_ADDI, 1, 0, 0, 77), 0);
    instr = encode(mk(I_SD, 0, 0, 1, 64));
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    wc = 0;
    while (!mem_req && wc < 10) begin
      @(negedge clk);
      wc++;
    end
    check_eq("mem_req_up", mem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_in_mem_req", mem_req, 1'b0);
    check_eq("rst_in_mem_pc", pc, 64'd0);
    model_reset();
    mem_ack = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("ack_ignored_req", mem_req, 1'b0);
    check_eq("ack_ignored_ready", instr_ready, 1'b1);
    mem_ack = 1'b0;
    run_instr(mk(I_SD, 0, 0, 1, 72), 0);
    check_eq("x1_after_reset", env_mem[64'd72], 64'd0);
    check_eq("ignored_store", env_mem.exists(64'd64), 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
